gate_envelope_ctrl: RTL and testbench
=====================================

// Module: gate_envelope_ctrl
// PURPOSE
//  Sequences the audio path from the noise-gate level detector. Consumes the detector's
//  binary open/closed strobe and a mic sample stream, and runs an attack/hold/release FSM.
//  The FSM ramps a 16-bit gain, which scales each sample, so the gate opens and closes
//  without clicks. Sits between the noise gate and the downstream effects/DAC path.
// PARAMETERS
//  WIDTH         16       sample width, signed two's complement
//  ATTACK_STEP   16'd2048 gain increment per accepted sample while in ATTACK
//  RELEASE_STEP  16'd64   gain decrement per accepted sample while in RELEASE
//  HOLD_SAMPLES  4800     samples held open after detector drops (0 = no hold)
//  HOLD_W        16       hold counter width; must satisfy HOLD_SAMPLES < 2**HOLD_W
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-low reset
//  det        in   WIDTH  detector output; only bit 0 is used (1 = level above threshold)
//  det_valid  in   1      det qualifier, single-cycle strobe
//  in         in   WIDTH  signed mic sample
//  in_valid   in   1      sample qualifier, single-cycle strobe
//  out        out  WIDTH  signed gated sample
//  out_valid  out  1      out qualifier, exactly 1 cycle after in_valid
//  gain       out  16     current gain, unsigned; UNITY = 16'h8000 (1.0)
//  gate_open  out  1      1 in ATTACK, OPEN or HOLD
//  state_o    out  3      FSM state, debug/LED
// BEHAVIOUR
//  Reset (rst=0, async): state=CLOSED, gain=0, det_q=0, hold_cnt=0, out=0, out_valid=0,
//   gate_open=0. Reset mid-ramp aborts the ramp immediately; no output is produced.
//  det_q is updated on det_valid. Effective detect value det_e = det_valid ? det[0] : det_q.
//   When det_valid and in_valid coincide, the new det value is used for that sample.
//  FSM advances only on in_valid cycles; every other register holds. Per accepted sample:
//   CLOSED : det_e=1 -> ATTACK.
//   ATTACK : det_e=0 -> RELEASE, gain unchanged. Else gain=min(gain+ATTACK_STEP, UNITY);
//            if the new gain equals UNITY -> OPEN.
//   OPEN   : det_e=0 -> HOLD with hold_cnt=HOLD_SAMPLES; if HOLD_SAMPLES==0 -> RELEASE directly.
//   HOLD   : det_e=1 -> OPEN. Else hold_cnt-=1; on reaching 0 -> RELEASE.
//   RELEASE: det_e=1 -> ATTACK (ramps up from the current gain).
//            Else gain=max(gain-RELEASE_STEP, 0); if the new gain equals 0 -> CLOSED.
//  Gain arithmetic: compute in 17 bits and saturate; the ramp never wraps, and gain is never
//   above UNITY or below 0.
//  Datapath: out = (in * $signed({1'b0,gain})) >>> 15 and uses the gain value from BEFORE this
//   sample's update. Product is 33-bit signed and is truncated toward -inf. At UNITY, out == in
//   bit-exact; at gain 0, out == 0.
//  Latency: out/out_valid are registered, 1 cycle after in_valid. out holds its value
//   when out_valid=0.
//  Back-to-back in_valid (every cycle) is supported at full rate.
//  gate_open and state_o are registered and reflect the post-update state.
// STRUCTURE
//  gate_pkg: typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} gate_state_t;
//   localparam UNITY = 16'h8000; GAIN_FRAC = 15.
//  Sub-module gain_mult: registered signed sample x unsigned Q1.15 gain, with valid pipeline
//   (1 cycle). The top level holds the FSM, det_q, hold counter and gain ramp.
// TESTING
//  1 Reset: rst=0 mid-ATTACK with gain=0x4000 -> gain=0, state=CLOSED, out_valid=0 in the
//    same cycle.
//  2 Attack: det=1, then samples in=1000, ATTACK_STEP=2048 -> outputs 0, 62, 125, ...
//    Gain reaches 0x8000 after 16 samples -> OPEN, and out==in thereafter.
//  3 Hold: OPEN, det=0, HOLD_SAMPLES=4 -> HOLD for 4 samples with gain=0x8000, then
//    RELEASE; det=1 during HOLD -> back to OPEN with gain unchanged.
//  4 Release to closed: gain=0x8000, RELEASE_STEP=64 -> 512 samples to gain 0 -> CLOSED.
//    in=-32768 at unity -> out=-32768.
//  5 Re-trigger: det=1 at RELEASE gain=0x3000 -> ATTACK from 0x3000; with step 2048,
//    OPEN after 10 samples. det_valid coincident with in_valid is honoured on that sample.
//  6 Saturation/stall: ATTACK_STEP=0x7000 -> gain 0x7000 then 0x8000, not 0xE000.
//    With no in_valid for 100 cycles, gain and state do not change.

Source files
------------

// File: rtl/gate_envelope_ctrl_pkg.sv
// gate_pkg: shared types and helpers for the noise-gate envelope controller.
//   gate_state_t : attack/hold/release FSM states (encoding is visible on state_o)
//   UNITY        : Q1.15 gain of 1.0
//   GAIN_FRAC    : fractional bits of the gain
//   gain_up/dn   : saturating gain ramp steps, computed in 17 bits
package gate_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    localparam logic [15:0] UNITY     = 16'h8000;
    localparam int          GAIN_FRAC = 15;

    // Ramp up, clamped at UNITY. The 17-bit sum cannot wrap for any step.
    function automatic logic [15:0] gain_up(input logic [15:0] g, input logic [15:0] step);
        logic [16:0] s;
        s = {1'b0, g} + {1'b0, step};
        return (s > {1'b0, UNITY}) ? UNITY : s[15:0];
    endfunction

    // Ramp down, clamped at 0. Bit 16 of the difference is the borrow.
    function automatic logic [15:0] gain_dn(input logic [15:0] g, input logic [15:0] step);
        logic [16:0] d;
        d = {1'b0, g} - {1'b0, step};
        return d[16] ? 16'd0 : d[15:0];
    endfunction

endpackage

// File: rtl/gate_envelope_ctrl_gain_mult.sv
// gain_mult: registered signed sample x unsigned Q1.15 gain, one-cycle latency.
//   clk, rst_n     : clock, async active-low reset
//   in_valid       : sample strobe; out_valid follows one cycle later
//   sample         : signed input sample
//   gain           : unsigned Q1.15 gain (0 .. UNITY)
//   out, out_valid : scaled sample (floor of product >> 15), held between strobes
module gain_mult
    import gate_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] sample,
    input  logic        [15:0]      gain,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid
);

    localparam int PW = WIDTH + 17;

    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] out_d, out_q;
    logic                    vld_d, vld_q;
    logic                    unused_prod;

    // Gain is zero-extended so it multiplies as a non-negative value.
    // Taking bits above GAIN_FRAC of a two's complement product is an
    // arithmetic shift, i.e. truncation toward -inf. Since gain <= UNITY
    // the result always fits WIDTH bits.
    assign prod        = PW'(sample) * PW'($signed({1'b0, gain}));
    assign unused_prod = ^{prod[PW-1:GAIN_FRAC+WIDTH], prod[GAIN_FRAC-1:0]};

    always_comb begin
        out_d = out_q;
        vld_d = in_valid;
        if (in_valid) out_d = prod[GAIN_FRAC +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: rtl/gate_envelope_ctrl.sv
// gate_envelope_ctrl: attack/hold/release envelope for the noise gate.
//   clk, rst          : clock, async active-low reset
//   det, det_valid    : detector level (bit 0) and its strobe; latched in det_q
//   in, in_valid      : signed mic sample and strobe; the FSM advances only here
//   out, out_valid    : gated sample, one cycle after in_valid
//   gain              : current Q1.15 gain (UNITY = 16'h8000)
//   gate_open         : high in ATTACK, OPEN or HOLD
//   state_o           : FSM state for debug/LED
module gate_envelope_ctrl
    import gate_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter logic [15:0] ATTACK_STEP  = 16'd2048,
    parameter logic [15:0] RELEASE_STEP = 16'd64,
    parameter int          HOLD_SAMPLES = 4800,
    parameter int          HOLD_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic        [WIDTH-1:0] det,
    input  logic                    det_valid,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid,
    output logic        [15:0]      gain,
    output logic                    gate_open,
    output logic        [2:0]       state_o
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);

    gate_state_t       state_d, state_q;
    logic [15:0]       gain_d, gain_q;
    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
    logic              det_d, det_q;
    logic              gate_open_d, gate_open_q;
    logic              det_e;
    logic [15:0]       gain_inc, gain_dec;
    logic [HOLD_W-1:0] hold_dec;
    logic              unused_det_hi;

    assign unused_det_hi = ^det[WIDTH-1:1];

    // A fresh detector strobe wins over the latched value on the same cycle.
    assign det_e    = det_valid ? det[0] : det_q;
    assign gain_inc = gain_up(gain_q, ATTACK_STEP);
    assign gain_dec = gain_dn(gain_q, RELEASE_STEP);
    assign hold_dec = hold_cnt_q - HOLD_W'(1);

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        hold_cnt_d = hold_cnt_q;
        det_d      = det_valid ? det[0] : det_q;

        if (in_valid) begin
            unique case (state_q)
                CLOSED: begin
                    if (det_e) state_d = ATTACK;
                end
                ATTACK: begin
                    // Detector drop freezes the gain and starts releasing from there.
                    if (!det_e) begin
                        state_d = RELEASE;
                    end else begin
                        gain_d = gain_inc;
                        if (gain_inc == UNITY) state_d = OPEN;
                    end
                end
                OPEN: begin
                    if (!det_e) begin
                        if (HOLD_SAMPLES == 0) begin
                            state_d = RELEASE;
                        end else begin
                            state_d    = HOLD;
                            hold_cnt_d = HOLD_INIT;
                        end
                    end
                end
                HOLD: begin
                    if (det_e) begin
                        state_d = OPEN;
                    end else begin
                        hold_cnt_d = hold_dec;
                        if (hold_dec == '0) state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (det_e) begin
                        state_d = ATTACK;
                    end else begin
                        gain_d = gain_dec;
                        if (gain_dec == 16'd0) state_d = CLOSED;
                    end
                end
                default: state_d = CLOSED;
            endcase
        end

        gate_open_d = (state_d == ATTACK) || (state_d == OPEN) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLOSED;
            gain_q      <= '0;
            hold_cnt_q  <= '0;
            det_q       <= 1'b0;
            gate_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_cnt_q  <= hold_cnt_d;
            det_q       <= det_d;
            gate_open_q <= gate_open_d;
        end
    end

    // Multiplier sees gain_q, i.e. the gain before this sample's ramp step.
    gain_mult #(
        .WIDTH(WIDTH)
    ) u_gain_mult (
        .clk      (clk),
        .rst_n    (rst),
        .in_valid (in_valid),
        .sample   (in),
        .gain     (gain_q),
        .out      (out),
        .out_valid(out_valid)
    );

    assign gain      = gain_q;
    assign gate_open = gate_open_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_gate_envelope_ctrl.sv
module tb_gate_envelope_ctrl;

    localparam int ND = 3;
    // Model state codes follow the documented debug encoding of state_o.
    localparam int S_CLOSED = 0, S_ATTACK = 1, S_OPEN = 2, S_HOLD = 3, S_RELEASE = 4;
    localparam int ATK[ND] = '{2048, 28672, 2048};
    localparam int REL[ND] = '{64, 64, 64};
    localparam int HSM[ND] = '{4, 4, 0};

    logic clk = 1'b0;
    logic rst;
    logic [15:0] det;
    logic det_valid;
    logic signed [15:0] x;
    logic in_valid;

    logic signed [15:0] o_out  [ND];
    logic               o_ov   [ND];
    logic        [15:0] o_gain [ND];
    logic               o_open [ND];
    logic        [2:0]  o_st   [ND];

    always #5 clk = ~clk;

    gate_envelope_ctrl #(.WIDTH(16), .ATTACK_STEP(16'd2048), .RELEASE_STEP(16'd64),
                         .HOLD_SAMPLES(4), .HOLD_W(16)) u_a (
        .clk(clk), .rst(rst), .det(det), .det_valid(det_valid), .in(x), .in_valid(in_valid),
        .out(o_out[0]), .out_valid(o_ov[0]), .gain(o_gain[0]), .gate_open(o_open[0]),
        .state_o(o_st[0]));

    gate_envelope_ctrl #(.WIDTH(16), .ATTACK_STEP(16'h7000), .RELEASE_STEP(16'd64),
                         .HOLD_SAMPLES(4), .HOLD_W(16)) u_s (
        .clk(clk), .rst(rst), .det(det), .det_valid(det_valid), .in(x), .in_valid(in_valid),
        .out(o_out[1]), .out_valid(o_ov[1]), .gain(o_gain[1]), .gate_open(o_open[1]),
        .state_o(o_st[1]));

    gate_envelope_ctrl #(.WIDTH(16), .ATTACK_STEP(16'd2048), .RELEASE_STEP(16'd64),
                         .HOLD_SAMPLES(0), .HOLD_W(16)) u_z (
        .clk(clk), .rst(rst), .det(det), .det_valid(det_valid), .in(x), .in_valid(in_valid),
        .out(o_out[2]), .out_valid(o_ov[2]), .gain(o_gain[2]), .gate_open(o_open[2]),
        .state_o(o_st[2]));

    // Behavioural reference model
    int m_st[ND], m_gain[ND], m_hold[ND], m_out[ND];
    bit m_ov[ND], m_detq[ND];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_st[k] = S_CLOSED; m_gain[k] = 0; m_hold[k] = 0;
            m_out[k] = 0; m_ov[k] = 0; m_detq[k] = 0;
        end
    endtask

    task automatic model_step();
        bit de;
        longint p;
        for (int k = 0; k < ND; k++) begin
            de = det_valid ? det[0] : m_detq[k];
            if (det_valid) m_detq[k] = det[0];
            m_ov[k] = in_valid;
            if (in_valid) begin
                p = longint'(int'(x)) * longint'(m_gain[k]);
                m_out[k] = int'(p >>> 15);
                case (m_st[k])
                    S_CLOSED: if (de) m_st[k] = S_ATTACK;
                    S_ATTACK: if (!de) m_st[k] = S_RELEASE;
                              else begin
                                  m_gain[k] += ATK[k];
                                  if (m_gain[k] >= 32768) begin m_gain[k] = 32768; m_st[k] = S_OPEN; end
                              end
                    S_OPEN:   if (!de) begin
                                  if (HSM[k] == 0) m_st[k] = S_RELEASE;
                                  else begin m_st[k] = S_HOLD; m_hold[k] = HSM[k]; end
                              end
                    S_HOLD:   if (de) m_st[k] = S_OPEN;
                              else begin
                                  m_hold[k]--;
                                  if (m_hold[k] == 0) m_st[k] = S_RELEASE;
                              end
                    default:  if (de) m_st[k] = S_ATTACK;
                              else begin
                                  m_gain[k] -= REL[k];
                                  if (m_gain[k] <= 0) begin m_gain[k] = 0; m_st[k] = S_CLOSED; end
                              end
                endcase
            end
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("d%0d.out_valid", k), int'(o_ov[k]), int'(m_ov[k]));
            chk($sformatf("d%0d.out", k), int'(o_out[k]), m_out[k]);
            chk($sformatf("d%0d.gain", k), int'(o_gain[k]), m_gain[k]);
            chk($sformatf("d%0d.state", k), int'(o_st[k]), m_st[k]);
            chk($sformatf("d%0d.gate_open", k), int'(o_open[k]),
                int'(m_st[k] == S_ATTACK || m_st[k] == S_OPEN || m_st[k] == S_HOLD));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic set_in(input bit d, input bit dv, input bit iv, input int v);
        det = {15'd0, d}; det_valid = dv; in_valid = iv; x = 16'(v);
    endtask

    // Synchronous-looking wrapper around an async reset pulse.
    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit d; bit dv; bit iv; int x;
        int e_out; bit e_ov; int e_gain; int e_st; bit e_open;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit lvl;
        logic [31:0] r;

        tbl[0]  = '{1, 1, 0, 1000,     0, 0,     0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1000,     0, 1,     0, 1, 1};
        tbl[2]  = '{1, 0, 1, 1000,     0, 1,  2048, 1, 1};
        tbl[3]  = '{1, 0, 1, 1000,    62, 1,  4096, 1, 1};
        tbl[4]  = '{1, 0, 1, 1000,   125, 1,  6144, 1, 1};
        tbl[5]  = '{1, 0, 1, -1000, -188, 1,  8192, 1, 1};
        tbl[6]  = '{1, 0, 0, 1000,  -188, 0,  8192, 1, 1};
        tbl[7]  = '{0, 1, 1, 1000,   250, 1,  8192, 4, 0};
        tbl[8]  = '{0, 0, 1, 1000,   250, 1,  8128, 4, 0};
        tbl[9]  = '{1, 1, 1, 1000,   248, 1,  8128, 1, 1};
        tbl[10] = '{1, 0, 1, 1000,   248, 1, 10176, 1, 1};

        // Reset state
        set_in(0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.gain", int'(o_gain[0]), 0);
        chk("reset.state", int'(o_st[0]), S_CLOSED);
        chk("reset.out_valid", int'(o_ov[0]), 0);
        chk("reset.out", int'(o_out[0]), 0);
        chk("reset.gate_open", int'(o_open[0]), 0);
        rst = 1'b1;

        // Table vectors: attack start, abort to release, coincident re-trigger
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].d, tbl[i].dv, tbl[i].iv, tbl[i].x);
            step();
            chk($sformatf("tbl%0d.out", i), int'(o_out[0]), tbl[i].e_out);
            chk($sformatf("tbl%0d.out_valid", i), int'(o_ov[0]), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.gain", i), int'(o_gain[0]), tbl[i].e_gain);
            chk($sformatf("tbl%0d.state", i), int'(o_st[0]), tbl[i].e_st);
            chk($sformatf("tbl%0d.gate_open", i), int'(o_open[0]), int'(tbl[i].e_open));
        end

        // Ramp to OPEN, then unity must be bit-exact
        set_in(1, 0, 1, 1000);
        cnt = 0;
        while (o_st[0] != 3'(S_OPEN) && cnt < 40) begin step(); cnt++; end
        chk("attack.state", int'(o_st[0]), S_OPEN);
        chk("attack.gain", int'(o_gain[0]), 32768);
        set_in(1, 0, 1, -32768); step(); step();
        chk("unity.neg", int'(o_out[0]), -32768);
        set_in(1, 0, 1, 32767); step(); step();
        chk("unity.pos", int'(o_out[0]), 32767);
        set_in(1, 0, 1, -12345); step(); step();
        chk("unity.mid", int'(o_out[0]), -12345);

        // Hold, interrupted by detector returning
        set_in(0, 1, 1, 500); step();
        chk("hold.enter", int'(o_st[0]), S_HOLD);
        set_in(0, 0, 1, 500); step(); step();
        chk("hold.still", int'(o_st[0]), S_HOLD);
        set_in(1, 1, 1, 500); step();
        chk("hold.reopen", int'(o_st[0]), S_OPEN);
        chk("hold.reopen_gain", int'(o_gain[0]), 32768);
        // Full hold, then release to closed
        set_in(0, 1, 1, 500); step();
        set_in(0, 0, 1, 500);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold.cnt%0d", i), int'(o_st[0]), S_HOLD);
            chk($sformatf("hold.gain%0d", i), int'(o_gain[0]), 32768);
        end
        step();
        chk("hold.to_release", int'(o_st[0]), S_RELEASE);
        chk("hold.release_gain", int'(o_gain[0]), 32768);
        cnt = 0;
        while (o_st[0] == 3'(S_RELEASE) && cnt < 600) begin
            r = $urandom; x = r[15:0];
            step(); cnt++;
        end
        chk("release.samples", cnt, 512);
        chk("release.state", int'(o_st[0]), S_CLOSED);
        chk("release.gain", int'(o_gain[0]), 0);

        // Re-trigger from mid-release with a coincident detector strobe
        set_in(1, 1, 1, 1000); step();
        set_in(1, 0, 1, 1000);
        repeat (6) step();
        chk("retrig.gain", int'(o_gain[0]), 12288);
        set_in(0, 1, 1, 1000); step();
        chk("retrig.release", int'(o_st[0]), S_RELEASE);
        set_in(1, 1, 1, 1000); step();
        chk("retrig.coincident", int'(o_st[0]), S_ATTACK);
        chk("retrig.start_gain", int'(o_gain[0]), 12288);
        set_in(1, 0, 1, 1000);
        cnt = 0;
        while (o_st[0] != 3'(S_OPEN) && cnt < 30) begin step(); cnt++; end
        chk("retrig.samples", cnt, 10);

        // Asynchronous reset in the middle of an attack ramp
        do_reset();
        set_in(1, 1, 1, 1000); step();
        set_in(1, 0, 1, 1000);
        repeat (8) step();
        chk("midrst.pre_gain", int'(o_gain[0]), 16384);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst.gain", int'(o_gain[0]), 0);
        chk("midrst.state", int'(o_st[0]), S_CLOSED);
        chk("midrst.out_valid", int'(o_ov[0]), 0);
        chk("midrst.out", int'(o_out[0]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0);

        // Saturation on the large-step instance, then a long stall
        set_in(1, 1, 1, 1000); step();
        set_in(1, 0, 1, 1000); step();
        chk("sat.first", int'(o_gain[1]), 28672);
        step();
        chk("sat.clamp", int'(o_gain[1]), 32768);
        chk("sat.state", int'(o_st[1]), S_OPEN);
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            det = r[15:0]; det_valid = r[16]; in_valid = 1'b0; x = r[31:16];
            step();
        end
        chk("stall.gain_s", int'(o_gain[1]), 32768);
        chk("stall.state_s", int'(o_st[1]), S_OPEN);
        chk("stall.gain_a", int'(o_gain[0]), 4096);
        chk("stall.state_a", int'(o_st[0]), S_ATTACK);

        // Randomized run against the model
        lvl = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            r = $urandom;
            if (r[31:26] == 6'd0) lvl = ~lvl;
            det = {r[15:1], lvl};
            det_valid = (r[18:16] == 3'd0);
            in_valid = (r[20:19] != 2'd0);
            r = $urandom;
            x = r[15:0];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
